// File: rtl/riscv_pkg.sv
// Shared encodings for the unified memory port: access sizes, arbiter states and port owners.
package riscv_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_be_gen.sv
// Byte-enable / store-lane generator for data accesses, with misalignment detection.
module mem_be_gen
  import riscv_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  always_comb begin
    o_be         = 4'b1111;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    case (i_size)
      SIZE_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SIZE_H: begin
        o_be         = 4'b0011 << i_addr_lo;
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_addr_lo[0];
      end
      SIZE_W:  o_misaligned = |i_addr_lo;
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; data has priority,
// bounded by a streak limit so a waiting fetch always makes progress.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_err,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int SW = $clog2(DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK);

  arb_state_e    r_state;
  owner_e        r_owner;
  logic [SW-1:0] r_streak;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_misaligned;
  logic        w_d_elig;
  logic        w_pick_d;
  logic        w_pick_if;
  logic        w_unused_if_lo;

  mem_be_gen u_be_gen (
    .i_size       (d_size),
    .i_addr_lo    (d_addr[1:0]),
    .i_wdata      (d_wdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned)
  );

  // A request that was just rejected is still held this cycle; keep it out of arbitration.
  assign w_d_elig       = d_req && !d_err;
  assign w_pick_d       = w_d_elig && !(if_req && (r_streak == STREAK_MAX));
  assign w_pick_if      = if_req && !w_pick_d;
  assign w_unused_if_lo = ^if_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_owner   <= OWN_IF;
      r_streak  <= '0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_err     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      d_err     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (!if_req) r_streak <= '0;
          if (w_pick_d) begin
            if (w_misaligned) begin
              d_err <= 1'b1;
            end else begin
              r_owner   <= OWN_D;
              d_gnt     <= 1'b1;
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= w_be;
              mem_wdata <= w_wdata;
              busy      <= 1'b1;
              r_state   <= ARB_REQ;
              if (if_req && (r_streak != STREAK_MAX)) r_streak <= r_streak + SW'(1);
            end
          end else if (w_pick_if) begin
            r_owner   <= OWN_IF;
            if_gnt    <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
            mem_be    <= 4'b1111;
            mem_wdata <= '0;
            busy      <= 1'b1;
            r_streak  <= '0;
            r_state   <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            r_state <= ARB_RSP;
          end
        end
        ARB_RSP: begin
          if (mem_rvalid) begin
            if (r_owner == OWN_D) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
            busy    <= 1'b0;
            r_state <= ARB_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: agents push expected transactions, a monitor checks them.
module tb_mem_port_arbiter;

  localparam int DS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_err, d_rvalid;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_STREAK(DS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_err(d_err), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    bit          is_d;
    bit          mis;
    bit          we;
    logic [31:0] addr_w;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t d_q[$], f_q[$], m_q[$], r_q[$];
  bit   gnt_log[$];
  exp_t me, cur;

  int errors = 0, checks = 0;
  int cyc = 0;
  int d_issue, f_issue;
  int last_d_gnt = -100, last_d_err = -100, last_d_rv = -100, last_if_gnt = -100, last_if_rv = -100;
  int n_mem_rise = 0, n_req_hi = 0, n_rv = 0, cnt = 0;
  logic [3:0]  last_be;
  logic [31:0] last_wd;
  bit prev_busy, prev_if_req, prev_d_req, prev_d_err, prev_mem_req, prev_mem_gnt;

  bit mem_auto = 1'b1;
  int gmin = 0, gmax = 0, rmin = 0, rmax = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Reference: bytes touched are [off, off+n); lane i carries byte (i mod n) of the store data.
  function automatic exp_t model_data(input bit we, input logic [1:0] sz, input logic [31:0] a,
                                      input logic [31:0] wd);
    exp_t e;
    int n, off;
    e.is_d = 1'b1; e.we = we; e.addr_w = a & 32'hFFFF_FFFC; e.be = '0; e.wdata = '0;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    off = int'(a[1:0]);
    if (n == 0) e.mis = 1'b1;
    else        e.mis = (off % n) != 0;
    if (!e.mis)
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + n) e.be[i] = 1'b1;
        e.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
      end
    return e;
  endfunction

  function automatic exp_t model_fetch(input logic [31:0] a);
    exp_t e;
    e.is_d = 1'b0; e.mis = 1'b0; e.we = 1'b0; e.addr_w = a & 32'hFFFF_FFFC;
    e.be = 4'b1111; e.wdata = '0;
    return e;
  endfunction

  function automatic logic [31:0] out_sig();
    return {16'b0, |if_rdata, |d_rdata, |mem_addr, |mem_wdata, mem_be,
            if_gnt, if_rvalid, d_gnt, d_err, d_rvalid, mem_req, mem_we, busy};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    int  gwait;
    bit  pend;
    int  rwait;
    logic [31:0] pdata;
    gwait = -1; pend = 1'b0; rwait = 0; pdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!mem_auto) continue;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (rst) begin
        pend = 1'b0; gwait = -1;
      end else if (pend) begin
        if (rwait == 0) begin
          mem_rvalid = 1'b1; mem_rdata = pdata; pend = 1'b0;
        end else rwait--;
      end else if (mem_req) begin
        if (gwait < 0) gwait = int'($urandom_range(gmax, gmin));
        if (gwait == 0) begin
          mem_gnt = 1'b1; gwait = -1; pend = 1'b1;
          rwait = int'($urandom_range(rmax, rmin));
          pdata = rd_model(mem_addr);
        end else gwait--;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      d_q.delete(); f_q.delete(); m_q.delete(); r_q.delete();
      cnt = 0;
    end else begin
      if (!prev_busy && !prev_if_req) cnt = 0;
      if (d_gnt || if_gnt) chk(!(d_gnt && if_gnt), "one_gnt", 32'({if_gnt, d_gnt}), 32'd1);
      if (d_gnt || d_err) begin
        if (d_q.size() == 0) chk(1'b0, "d_unexpected", 32'({d_gnt, d_err}), 32'd0);
        else begin
          me = d_q.pop_front();
          chk(me.mis == d_err, "d_gnt_vs_err", 32'(d_err), 32'(me.mis));
          if (d_gnt) begin
            m_q.push_back(me); gnt_log.push_back(1'b1); last_d_gnt = cyc;
            if (prev_if_req) begin
              chk(cnt < DS, "streak_d", 32'(cnt), 32'(DS - 1));
              cnt++;
            end
          end else begin
            last_d_err = cyc;
            chk(!mem_req, "err_no_mem", 32'(mem_req), 32'd0);
          end
        end
      end
      if (if_gnt) begin
        if (f_q.size() == 0) chk(1'b0, "if_unexpected", 32'(if_gnt), 32'd0);
        else begin
          me = f_q.pop_front();
          m_q.push_back(me); gnt_log.push_back(1'b0); last_if_gnt = cyc;
          if (prev_d_req && !prev_d_err) chk(cnt == DS, "streak_if", 32'(cnt), 32'(DS));
          cnt = 0;
        end
      end
      if (mem_req && !prev_mem_req) begin
        n_mem_rise++;
        if (m_q.size() == 0) chk(1'b0, "mem_unexpected", mem_addr, 32'd0);
        else begin
          cur = m_q.pop_front();
          last_be = mem_be; last_wd = mem_wdata;
          chk(mem_we == cur.we, "mem_we", 32'(mem_we), 32'(cur.we));
          chk(mem_addr == cur.addr_w, "mem_addr", mem_addr, cur.addr_w);
          chk(mem_be == cur.be, "mem_be", 32'(mem_be), 32'(cur.be));
          if (cur.we) chk(mem_wdata == cur.wdata, "mem_wdata", mem_wdata, cur.wdata);
        end
      end
      if (mem_req) n_req_hi++;
      if (prev_mem_req && !prev_mem_gnt) chk(mem_req, "req_held", 32'(mem_req), 32'd1);
      if (mem_req && mem_gnt) begin
        chk(mem_addr == cur.addr_w && mem_be == cur.be && mem_we == cur.we,
            "req_stable", mem_addr, cur.addr_w);
        r_q.push_back(cur);
      end
      if (if_rvalid || d_rvalid) begin
        n_rv++;
        if (d_rvalid) last_d_rv = cyc;
        if (if_rvalid) last_if_rv = cyc;
        if (r_q.size() == 0) chk(1'b0, "rsp_unexpected", 32'({if_rvalid, d_rvalid}), 32'd0);
        else begin
          me = r_q.pop_front();
          chk(!(if_rvalid && d_rvalid) && (me.is_d == d_rvalid), "rsp_owner",
              32'({if_rvalid, d_rvalid}), me.is_d ? 32'd1 : 32'd2);
          chk((d_rvalid ? d_rdata : if_rdata) == rd_model(me.addr_w), "rsp_data",
              d_rvalid ? d_rdata : if_rdata, rd_model(me.addr_w));
        end
      end
    end
    prev_busy = busy; prev_if_req = if_req; prev_d_req = d_req; prev_d_err = d_err;
    prev_mem_req = mem_req; prev_mem_gnt = mem_gnt;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_data(input bit we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int k;
    d_q.push_back(model_data(we, sz, a, wd));
    d_we = we; d_size = sz; d_addr = a; d_wdata = wd; d_req = 1'b1; d_issue = cyc;
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (!(d_gnt || d_err) && k < 300);
    if (!(d_gnt || d_err)) chk(1'b0, "d_timeout", 32'(k), 32'd300);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    int k;
    f_q.push_back(model_fetch(a));
    if_addr = a; if_req = 1'b1; f_issue = cyc;
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (!if_gnt && k < 300);
    if (!if_gnt) chk(1'b0, "if_timeout", 32'(k), 32'd300);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, hi, rv;
    logic [31:0] lb;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_size = '0;
    d_addr = '0; d_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk(out_sig() == 0, "reset_outputs", out_sig(), 32'd0);
    rst = 1'b0;
    idle(2);

    do_fetch(32'h0000_0100);
    idle(4);
    chk(last_if_gnt == f_issue + 1, "fetch_gnt_latency", 32'(last_if_gnt), 32'(f_issue + 1));
    chk(last_if_rv == f_issue + 3, "fetch_rvalid_latency", 32'(last_if_rv), 32'(f_issue + 3));
    chk(!busy, "busy_after_fetch", 32'(busy), 32'd0);

    fork
      do_data(1'b0, 2'b10, 32'h0000_0200, 32'd0);
      do_fetch(32'h0000_0206);
    join
    idle(6);
    chk(last_d_gnt == d_issue + 1, "simul_data_first", 32'(last_d_gnt), 32'(d_issue + 1));
    chk(last_if_gnt == last_d_rv + 1, "simul_fetch_after_drv", 32'(last_if_gnt), 32'(last_d_rv + 1));

    gnt_log.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) do_data(1'b0, 2'b10, 32'h300 + 32'(4 * i), 32'd0);
      end
      do_fetch(32'h0000_03F0);
    join
    idle(6);
    lb = '0;
    foreach (gnt_log[i]) lb = {lb[30:0], gnt_log[i]};
    chk(gnt_log.size() == 7, "streak_grant_count", 32'(gnt_log.size()), 32'd7);
    chk(lb == 32'b1111011, "streak_grant_order", lb, 32'b1111011);

    do_data(1'b1, 2'b00, 32'h0000_0203, 32'h0000_00AB);
    idle(4);
    chk(last_be == 4'b1000, "sb_be", 32'(last_be), 32'h8);
    chk(last_wd == 32'hABABABAB, "sb_wdata", last_wd, 32'hABABABAB);
    do_data(1'b1, 2'b01, 32'h0000_0202, 32'h1234_BEEF);
    idle(4);
    chk(last_wd == 32'hBEEFBEEF, "sh_wdata", last_wd, 32'hBEEFBEEF);
    rises = n_mem_rise;
    do_data(1'b1, 2'b10, 32'h0000_0202, 32'h1234_5678);
    idle(3);
    chk(last_d_err == d_issue + 1, "sw_mis_err", 32'(last_d_err), 32'(d_issue + 1));
    chk(n_mem_rise == rises, "sw_mis_no_req", 32'(n_mem_rise), 32'(rises));

    gmin = 5; gmax = 5;
    hi = n_req_hi; rv = n_rv;
    do_data(1'b0, 2'b10, 32'h0000_0500, 32'd0);
    idle(10);
    chk(n_req_hi - hi == 6, "stall_req_cycles", 32'(n_req_hi - hi), 32'd6);
    chk(n_rv - rv == 1, "stall_single_rvalid", 32'(n_rv - rv), 32'd1);
    gmin = 0; gmax = 0;

    mem_auto = 1'b0;
    idle(1);
    rv = n_rv;
    do_fetch(32'h0000_0400);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk(busy, "rsp_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk(out_sig() == 0, "rst_mid_outputs", out_sig(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    idle(3);
    chk(n_rv == rv, "rst_no_rvalid", 32'(n_rv), 32'(rv));
    chk(out_sig() == 0, "rst_after_outputs", out_sig(), 32'd0);
    mem_auto = 1'b1;

    gmin = 0; gmax = 3; rmin = 0; rmax = 3;
    fork
      begin
        logic [1:0] sz;
        for (int i = 0; i < 60; i++) begin
          idle(int'($urandom_range(3, 0)));
          sz = ($urandom_range(7, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
          do_data(1'($urandom_range(1, 0)), sz, 32'h1000 + $urandom_range(255, 0), $urandom);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          idle(int'($urandom_range(4, 0)));
          do_fetch(32'h2000 + $urandom_range(1023, 0));
        end
      end
    join
    idle(20);
    chk(d_q.size() + f_q.size() + m_q.size() + r_q.size() == 0, "drain",
        32'(d_q.size() + f_q.size() + m_q.size() + r_q.size()), 32'd0);
    chk(!busy, "final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
